// File: rtl/shift_right.sv
// -----------------------------------------------------------------------------
// shift_right
//
// Registered symbol-granular shifter. The packed input vector holds
// NUM_SYMBOLS symbols of SYMBOL_WIDTH bits each. Symbol k occupies
// bits [SYMBOL_WIDTH*(k+1)-1 : SYMBOL_WIDTH*k]. The vector is moved by
// 0..MAX_SHIFT symbol positions toward the high end. Vacated low-order slots
// are loaded with the fill symbol. Symbols shifted past the top are dropped
// and never wrap around. The result appears exactly one clock after sampling.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset (clears out and out_valid)
//   in         source vector, SYMBOL_WIDTH*NUM_SYMBOLS bits
//   shift      shift amount in symbols, SHIFT_WIDTH bits
//   fill       symbol written into every vacated slot
//   out_valid  high when out holds the result of a legal shift
//   out        shifted vector (registered)
//
// Parameter constraints:
//   MAX_SHIFT must be less than NUM_SYMBOLS.
//   MAX_SHIFT must be no greater than 2**SHIFT_WIDTH-1.
//
// Configuration macro:
//   SHIFT_RIGHT_HOLD_EN
//     Defined:   an illegal shift keeps the previous out value and drives
//                out_valid low.
//     Undefined: an illegal shift forces out to zero and drives out_valid low.
//                This is the default build.
// -----------------------------------------------------------------------------
module shift_right #(
    parameter int SYMBOL_WIDTH = 5,
    parameter int NUM_SYMBOLS  = 10,
    parameter int SHIFT_WIDTH  = 3,
    parameter int MAX_SHIFT    = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [SYMBOL_WIDTH*NUM_SYMBOLS-1:0] in,
    input  logic [SHIFT_WIDTH-1:0]              shift,
    input  logic [SYMBOL_WIDTH-1:0]             fill,
    output logic                                out_valid,
    output logic [SYMBOL_WIDTH*NUM_SYMBOLS-1:0] out
);

    localparam int VEC_W = SYMBOL_WIDTH * NUM_SYMBOLS;

    // Same width as shift, so the legality compare has no width mismatch.
    localparam logic [SHIFT_WIDTH-1:0] MAX_SHIFT_L = SHIFT_WIDTH'(MAX_SHIFT);

    logic [VEC_W-1:0] out_q;
    logic [VEC_W-1:0] out_d;
    logic             vld_q;
    logic             vld_d;

    logic             legal;
    logic [VEC_W-1:0] shifted;
    logic [VEC_W-1:0] fill_vec;
    logic [VEC_W-1:0] low_mask;

    assign legal = (shift <= MAX_SHIFT_L);

    // A whole-vector bit shift by shift*SYMBOL_WIDTH moves every symbol up by
    // shift slots and zero-fills the bottom. The mask has ones in the vacated
    // slots, and the replicated fill symbol is ORed into exactly those bits.
    // With shift = 0 the mask is all zeros, so fill has no effect.
    assign shifted  = in << (int'(shift) * SYMBOL_WIDTH);
    assign fill_vec = {NUM_SYMBOLS{fill}};
    assign low_mask = ~({VEC_W{1'b1}} << (int'(shift) * SYMBOL_WIDTH));

    always_comb begin
        out_d = '0;
        vld_d = 1'b0;
        if (legal) begin
            out_d = shifted | (fill_vec & low_mask);
            vld_d = 1'b1;
        end else begin
`ifdef SHIFT_RIGHT_HOLD_EN
            out_d = out_q;
`else
            out_d = '0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
            vld_q <= 1'b0;
        end else begin
            out_q <= out_d;
            vld_q <= vld_d;
        end
    end

    assign out       = out_q;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_shift_right.sv
module tb_shift_right;

    logic        clk;
    logic        rst;
    logic [49:0] din;
    logic [2:0]  shift;
    logic [4:0]  fill;
    logic        out_valid;
    logic [49:0] dout;

    int vectors;
    int miscompares;

    logic [49:0] exp_out;
    logic [49:0] held;

    shift_right dut (
        .clk       (clk),
        .rst       (rst),
        .in        (din),
        .shift     (shift),
        .fill      (fill),
        .out_valid (out_valid),
        .out       (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [49:0] obs, input logic [49:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Drive one input set, let one rising edge capture it, then sample 1 ns later.
    task automatic step(input logic [49:0] i_v, input logic [2:0] s_v, input logic [4:0] f_v);
        din   = i_v;
        shift = s_v;
        fill  = f_v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst   = 1'b1;
        din   = '0;
        shift = '0;
        fill  = '0;

        // Reset state
        #2;
        chk("reset_out", dout, 50'h0);
        chk("reset_vld", {49'h0, out_valid}, 50'h0);
        @(posedge clk);
        #1;
        chk("reset_hold_out", dout, 50'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Zero shift
        step({10{5'h01}}, 3'd0, 5'h00);
        chk("zero_out", dout, {10{5'h01}});
        chk("zero_vld", {49'h0, out_valid}, 50'h1);

        // Shift by 1
        step({10{5'h02}}, 3'd1, 5'h01);
        chk("sh1_out", dout, {{9{5'h02}}, 5'h01});
        chk("sh1_vld", {49'h0, out_valid}, 50'h1);

        // Shift by 4 (largest legal), then shift by 2 on the next cycle
        step({10{5'h09}}, 3'd4, 5'h1F);
        chk("sh4_out", dout, {{6{5'h09}}, {4{5'h1F}}});
        chk("sh4_vld", {49'h0, out_valid}, 50'h1);
        step({10{5'h0A}}, 3'd2, 5'h03);
        chk("sh2_out", dout, {{8{5'h0A}}, {2{5'h03}}});
        chk("sh2_vld", {49'h0, out_valid}, 50'h1);
        held = {{8{5'h0A}}, {2{5'h03}}};

        // Illegal shifts
`ifdef SHIFT_RIGHT_HOLD_EN
        exp_out = held;
`else
        exp_out = 50'h0;
`endif
        step({10{5'h15}}, 3'd5, 5'h07);
        chk("ill5_out", dout, exp_out);
        chk("ill5_vld", {49'h0, out_valid}, 50'h0);
        step({10{5'h16}}, 3'd7, 5'h0A);
        chk("ill7_out", dout, exp_out);
        chk("ill7_vld", {49'h0, out_valid}, 50'h0);

        // Distinct symbols: symbol k = k+1, shift 3, fill 1E
        step({5'd10, 5'd9, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1}, 3'd3, 5'h1E);
        chk("dist_out", dout, {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'h1E, 5'h1E, 5'h1E});
        chk("dist_vld", {49'h0, out_valid}, 50'h1);

        // Shift 0 ignores a nonzero fill
        step({5'd10, 5'd9, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1}, 3'd0, 5'h1F);
        chk("zero_fill_ign", dout, {5'd10, 5'd9, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1});

        // Shift 4 with distinct symbols: top four are discarded, no wrap
        step({5'd10, 5'd9, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1}, 3'd4, 5'h00);
        chk("sh4_dist", dout, {5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'h00, 5'h00, 5'h00, 5'h00});

        // Illegal shift 6, then a legal shift resumes
        held = {5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'h00, 5'h00, 5'h00, 5'h00};
`ifdef SHIFT_RIGHT_HOLD_EN
        exp_out = held;
`else
        exp_out = 50'h0;
`endif
        step({10{5'h1F}}, 3'd6, 5'h1F);
        chk("ill6_out", dout, exp_out);
        chk("ill6_vld", {49'h0, out_valid}, 50'h0);
        step({10{5'h00}}, 3'd1, 5'h1F);
        chk("resume_out", dout, {{9{5'h00}}, 5'h1F});
        chk("resume_vld", {49'h0, out_valid}, 50'h1);

        // Asynchronous reset mid-cycle, with a valid output present
        step({10{5'h11}}, 3'd0, 5'h00);
        chk("pre_rst_out", dout, {10{5'h11}});
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out", dout, 50'h0);
        chk("async_rst_vld", {49'h0, out_valid}, 50'h0);
        @(negedge clk);
        rst = 1'b0;

        // After reset, an illegal shift gives zero in both builds
        step({10{5'h12}}, 3'd5, 5'h04);
        chk("post_rst_ill", dout, 50'h0);
        step({10{5'h13}}, 3'd2, 5'h04);
        chk("post_rst_sh2", dout, {{8{5'h13}}, {2{5'h04}}});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no_finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
